unidade_busca: RTL
==================

# unidade_busca

Instruction fetch/decode stage of the nRISC core, directly upstream of the register bank. Fetches one 8-bit instruction per request from instruction memory over a req/ack handshake, holds it in an instruction register, and decodes the register-select and write-enable fields that drive the bank's `reg1`, `reg2` and `regWrite` inputs. Handles downstream stall and taken-branch redirect, including a branch that arrives while a fetch is outstanding.

## Interface
- `RESET_PC`, 8'h00, fetch address loaded on reset.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  downstream busy; hold the current instruction.
- `desvio`  in  1  taken branch/jump from execute; redirect fetch.
- `alvoDesvio`  in  8  branch target address, valid with `desvio`.
- `memReq`  out  1  instruction memory request.
- `memEndereco`  out  8  instruction memory address.
- `memAck`  in  1  memory response valid; `memDado` valid same cycle.
- `memDado`  in  8  fetched instruction byte.
- `instrucao`  out  8  instruction register.
- `opcode`  out  4  `instrucao[7:4]`.
- `reg1`  out  2  `instrucao[3:2]`; destination/first source to register bank.
- `reg2`  out  2  `instrucao[1:0]`; second source to register bank.
- `regWrite`  out  1  one-cycle write enable to register bank.
- `valido`  out  1  `instrucao` holds a live instruction.
- `pc`  out  8  address of the instruction in `instrucao`.

## Operation
- Registers: `pcBusca` (next fetch address), `instrucao`, `pc`, state.
- States: BUSCA, EMITE, DESCARTE.
- BUSCA: `memReq`=1, `memEndereco`=`pcBusca`, `valido`=0. On `memAck` & !`desvio`: `instrucao`<=`memDado`, `pc`<=`pcBusca`, `pcBusca`<=`pcBusca`+1, go EMITE. On `desvio` without `memAck`: `pcBusca`<=`alvoDesvio`, go DESCARTE. On `desvio` with `memAck`: discard data, `pcBusca`<=`alvoDesvio`, stay BUSCA.
- EMITE: `memReq`=0, `valido`=1. If `desvio`: `pcBusca`<=`alvoDesvio`, go BUSCA (instruction killed). Else if !`stall`: go BUSCA. Else hold.
- DESCARTE: `memReq`=1 held at the old address (request is not withdrawn); wait for `memAck`, discard `memDado`, go BUSCA. A further `desvio` here overwrites `pcBusca`.
- Decode: `regWrite` = (state==EMITE) & !`opcode[3]` & !`stall` & !`desvio` (opcodes 0x0–0x7 write `reg1`; 0x8–0xF do not). Combinational from registered state plus `stall`/`desvio`.
- Arithmetic: `pcBusca`+1 is 8-bit modulo; 8'hFF wraps to 8'h00.
- Priority: reset > `desvio` > `stall`.

## Timing
- Reset values: `memReq`=0, `memEndereco`=`RESET_PC`, `instrucao`=0, `opcode`/`reg1`/`reg2`=0, `regWrite`=0, `valido`=0, `pc`=0, state BUSCA, `pcBusca`=`RESET_PC`.
- `memReq` is 0 while `reset` is high. It asserts in the first cycle after `reset` deasserts.
- Minimum 2 cycles per instruction: BUSCA with same-cycle `memAck`, then EMITE. Each memory wait cycle adds one.
- `regWrite` is high for exactly one cycle per writing instruction: the EMITE cycle in which `stall`=0. This matches the bank's negedge write within that cycle.
- `memReq`/`memEndereco` are stable from assertion until `memAck`, including across `desvio`.
- Reset mid-fetch: the outstanding request is abandoned. Memory must not return `memAck` for it after reset.

## Test plan
- Reset, memory acks immediately with 0x24,0x9B -> `memEndereco` 0x00,0x01. `instrucao`=0x24 with `reg1`=1, `reg2`=0, `regWrite` pulse 1 cycle. Then 0x9B with `regWrite`=0.
- `stall` held 3 cycles in EMITE (opcode 0x3) -> `valido`=1, `instrucao` stable, `regWrite`=0 during stall, single pulse on release, no new `memReq`.
- `desvio` in EMITE, `alvoDesvio`=0x40 -> `regWrite` never asserted for killed instruction. Next `memEndereco`=0x40, `pc`=0x40 after ack.
- `desvio`(0x80) in BUSCA, ack delayed 2 cycles -> DESCARTE holds old address until ack. Data discarded, `valido` stays 0, next fetch at 0x80.
- Fetch from 0xFF -> `pc`=0xFF, next `memEndereco`=0x00.
- Assert `reset` during memory wait -> outputs return to reset values asynchronously. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/unidade_busca_if.sv
// Fetch/decode bundle: instruction-memory handshake, pipeline control, decoded outputs.
// Memory side: memReq/memEndereco out, memAck/memDado in (data valid with ack).
// Pipeline side: stall/desvio/alvoDesvio in; instrucao/opcode/reg1/reg2/regWrite/valido/pc out.
interface unidade_busca_if;
   // pipeline control from downstream/execute
   logic       stall;
   logic       desvio;
   logic [7:0] alvoDesvio;
   // instruction memory handshake
   logic       memReq;
   logic [7:0] memEndereco;
   logic       memAck;
   logic [7:0] memDado;
   // decoded instruction towards the register bank
   logic [7:0] instrucao;
   logic [3:0] opcode;
   logic [1:0] reg1;
   logic [1:0] reg2;
   logic       regWrite;
   logic       valido;
   logic [7:0] pc;

   // master: the fetch unit itself
   modport master (
      input  stall, desvio, alvoDesvio, memAck, memDado,
      output memReq, memEndereco, instrucao, opcode, reg1, reg2, regWrite, valido, pc
   );

   // slave: memory + pipeline environment around the fetch unit
   modport slave (
      output stall, desvio, alvoDesvio, memAck, memDado,
      input  memReq, memEndereco, instrucao, opcode, reg1, reg2, regWrite, valido, pc
   );
endinterface

// File: rtl/unidade_busca.sv
// Instruction fetch/decode stage of the nRISC core, feeding the register bank.
// Latency: 2 cycles per instruction minimum (BUSCA with same-cycle ack, then EMITE); +1 per memory wait cycle.
// Backpressure: stall holds the instruction in EMITE with no new request; desvio overrides stall.
// Ports: clock/reset (async, active-high); bus (master modport) carries memReq/memEndereco/
//        memAck/memDado, stall/desvio/alvoDesvio, and instrucao/opcode/reg1/reg2/regWrite/valido/pc.
module unidade_busca #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic              clock,
   input  logic              reset,
   unidade_busca_if.master   bus
);

   typedef enum logic [1:0] {
      BUSCA    = 2'd0,   // request outstanding at pc_busca_q
      EMITE    = 2'd1,   // instrucao_q is live, no request
      DESCARTE = 2'd2    // old request still outstanding, its data will be dropped
   } estado_t;

   estado_t    estado_q, estado_d;
   logic [7:0] pc_busca_q, pc_busca_d;    // next fetch address
   logic [7:0] end_pend_q, end_pend_d;    // address of a request made obsolete by desvio
   logic [7:0] instrucao_q, instrucao_d;
   logic [7:0] pc_q, pc_d;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= BUSCA;
         pc_busca_q  <= RESET_PC;
         end_pend_q  <= RESET_PC;
         instrucao_q <= 8'h00;
         pc_q        <= 8'h00;
      end else begin
         estado_q    <= estado_d;
         pc_busca_q  <= pc_busca_d;
         end_pend_q  <= end_pend_d;
         instrucao_q <= instrucao_d;
         pc_q        <= pc_d;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      estado_d    = estado_q;
      pc_busca_d  = pc_busca_q;
      end_pend_d  = end_pend_q;
      instrucao_d = instrucao_q;
      pc_d        = pc_q;

      case (estado_q)
         BUSCA: begin
            if (bus.desvio) begin
               pc_busca_d = bus.alvoDesvio;
               if (!bus.memAck) begin
                  // The request cannot be withdrawn: keep driving its
                  // address until the memory answers, then drop the data.
                  end_pend_d = pc_busca_q;
                  estado_d   = DESCARTE;
               end
               // desvio with ack: data dropped, new request next cycle
            end else if (bus.memAck) begin
               instrucao_d = bus.memDado;
               pc_d        = pc_busca_q;
               pc_busca_d  = pc_busca_q + 8'd1;   // wraps 0xFF -> 0x00
               estado_d    = EMITE;
            end
         end

         EMITE: begin
            if (bus.desvio) begin
               pc_busca_d = bus.alvoDesvio;
               estado_d   = BUSCA;
            end else if (!bus.stall) begin
               estado_d   = BUSCA;
            end
         end

         DESCARTE: begin
            // Later branches only retarget the next fetch; the pending
            // address on the bus stays put.
            if (bus.desvio) begin
               pc_busca_d = bus.alvoDesvio;
            end
            if (bus.memAck) begin
               estado_d = BUSCA;
            end
         end

         default: begin
            estado_d = BUSCA;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   always_comb begin
      bus.memReq      = 1'b0;
      bus.memEndereco = pc_busca_q;
      bus.valido      = 1'b0;

      case (estado_q)
         BUSCA: begin
            bus.memReq = 1'b1;
         end
         EMITE: begin
            bus.valido = 1'b1;
         end
         DESCARTE: begin
            bus.memReq      = 1'b1;
            bus.memEndereco = end_pend_q;
         end
         default: begin
            bus.memReq = 1'b0;
         end
      endcase

      // State already reads BUSCA while reset is held; the request must
      // not appear until reset is released.
      if (reset) begin
         bus.memReq = 1'b0;
      end
   end

   assign bus.instrucao = instrucao_q;
   assign bus.pc        = pc_q;
   assign bus.opcode    = instrucao_q[7:4];
   assign bus.reg1      = instrucao_q[3:2];
   assign bus.reg2      = instrucao_q[1:0];

   // Opcodes 0x0-0x7 write reg1. The pulse lands in the single EMITE
   // cycle where the instruction is released downstream, so a stalled
   // or killed instruction never writes.
   assign bus.regWrite = (estado_q == EMITE) & ~instrucao_q[7] & ~bus.stall & ~bus.desvio;

endmodule
